// File: rtl/gemips_pkg.sv
// Shared definitions for the register-file write-back path: requester IDs,
// register widths and the slot entry record.
package gemips_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [1:0] WB_REQ_PIPE = 2'd0;
  localparam logic [1:0] WB_REQ_MDU  = 2'd1;
  localparam logic [1:0] WB_REQ_LSU  = 2'd2;
  localparam logic [1:0] WB_REQ_NONE = 2'd3;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

  // One-hot register bit for a live write; r0 never shows up as pending.
  function automatic logic [31:0] reg_onehot(input logic valid, input logic [REG_AW-1:0] addr);
    logic [31:0] mask;
    mask = '0;
    if (valid && addr != REG_ZERO) mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding slot for a write-back producer. Writes to r0 are
// swallowed at acceptance so they never become valid.
//
// Handshake: a transfer happens at a posedge when in_valid & ready. ready is
// ~valid | grant, so a slot being drained this cycle can be refilled in the
// same edge and stream one write per cycle. The producer keeps in_addr and
// in_data stable while in_valid is high and ready is low.
module wb_slot
  import gemips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_addr,
  input  logic [REG_DW-1:0] in_data,
  input  logic              grant,
  output logic              ready,
  output wb_entry_t         entry
);

  logic take;

  assign ready = ~entry.valid | grant;
  assign take  = in_valid & ready;

  // Load on transfer (refill wins over drain), otherwise drop on grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry <= '0;
    end else if (take) begin
      entry.valid <= (in_addr != REG_ZERO);
      entry.addr  <= in_addr;
      entry.data  <= in_data;
    end else if (grant) begin
      entry.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the pipeline
// (fixed priority), the mul/div unit and the load/refill path (round-robin
// between those two, with a starvation guard). The port is registered so it
// is stable across the register file's negedge write.
module regfile_wb_arbiter
  import gemips_pkg::*;
#(
  parameter int STARVE_LIMIT = 4  // legal 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  input  logic              req_valid_2,
  output logic              req_ready_0,
  output logic              req_ready_1,
  output logic              req_ready_2,
  input  logic [REG_AW-1:0] req_addr_0,
  input  logic [REG_AW-1:0] req_addr_1,
  input  logic [REG_AW-1:0] req_addr_2,
  input  logic [REG_DW-1:0] req_data_0,
  input  logic [REG_DW-1:0] req_data_1,
  input  logic [REG_DW-1:0] req_data_2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [REG_DW-1:0] rf_wdata,
  output logic [1:0]        grant_id,
  output logic [31:0]       pending_mask
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_entry_t  slot_0, slot_1, slot_2;
  wb_entry_t  win_entry;
  logic       grant_0, grant_1, grant_2;
  logic       starve_hit_1, starve_hit_2;
  logic [3:0] starve_cnt_1, starve_cnt_2;
  logic       rr_ptr;  // 0 = mul/div next, 1 = load/refill next
  logic [1:0] win_id;

  wb_slot u_slot_0 (
    .clk(clk), .rst(rst), .in_valid(req_valid_0), .in_addr(req_addr_0),
    .in_data(req_data_0), .grant(grant_0), .ready(req_ready_0), .entry(slot_0)
  );

  wb_slot u_slot_1 (
    .clk(clk), .rst(rst), .in_valid(req_valid_1), .in_addr(req_addr_1),
    .in_data(req_data_1), .grant(grant_1), .ready(req_ready_1), .entry(slot_1)
  );

  wb_slot u_slot_2 (
    .clk(clk), .rst(rst), .in_valid(req_valid_2), .in_addr(req_addr_2),
    .in_data(req_data_2), .grant(grant_2), .ready(req_ready_2), .entry(slot_2)
  );

  // Winner selection: starved secondary first, then pipeline, then round-robin.
  always_comb begin
    starve_hit_1 = slot_1.valid && (starve_cnt_1 >= LIMIT);
    starve_hit_2 = slot_2.valid && (starve_cnt_2 >= LIMIT);
    win_id       = WB_REQ_NONE;
    if (starve_hit_1 && starve_hit_2)    win_id = rr_ptr ? WB_REQ_LSU : WB_REQ_MDU;
    else if (starve_hit_1)               win_id = WB_REQ_MDU;
    else if (starve_hit_2)               win_id = WB_REQ_LSU;
    else if (slot_0.valid)               win_id = WB_REQ_PIPE;
    else if (slot_1.valid && slot_2.valid) win_id = rr_ptr ? WB_REQ_LSU : WB_REQ_MDU;
    else if (slot_1.valid)               win_id = WB_REQ_MDU;
    else if (slot_2.valid)               win_id = WB_REQ_LSU;
    grant_0 = (win_id == WB_REQ_PIPE);
    grant_1 = (win_id == WB_REQ_MDU);
    grant_2 = (win_id == WB_REQ_LSU);
  end

  // Route the winning slot's contents toward the output register.
  always_comb begin
    win_entry = '0;
    case (win_id)
      WB_REQ_PIPE: win_entry = slot_0;
      WB_REQ_MDU:  win_entry = slot_1;
      WB_REQ_LSU:  win_entry = slot_2;
      default:     win_entry = '0;
    endcase
  end

  // Starve counters and round-robin pointer for the two secondary slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_1 <= '0;
      starve_cnt_2 <= '0;
      rr_ptr       <= 1'b0;
    end else begin
      if (!slot_1.valid || grant_1)  starve_cnt_1 <= '0;
      else if (starve_cnt_1 < LIMIT) starve_cnt_1 <= starve_cnt_1 + 4'd1;
      if (!slot_2.valid || grant_2)  starve_cnt_2 <= '0;
      else if (starve_cnt_2 < LIMIT) starve_cnt_2 <= starve_cnt_2 + 4'd1;
      if (grant_1)      rr_ptr <= 1'b1;
      else if (grant_2) rr_ptr <= 1'b0;
    end
  end

  // Registered write port; address/data hold while no write is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= WB_REQ_NONE;
    end else begin
      rf_we    <= win_entry.valid;
      grant_id <= win_id;
      if (win_entry.valid) begin
        rf_waddr <= win_entry.addr;
        rf_wdata <= win_entry.data;
      end
    end
  end

  // Registers with a write still buffered or on the port this cycle.
  always_comb begin
    pending_mask = reg_onehot(slot_0.valid, slot_0.addr)
                 | reg_onehot(slot_1.valid, slot_1.addr)
                 | reg_onehot(slot_2.valid, slot_2.addr)
                 | reg_onehot(rf_we, rf_waddr);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-cycle vector table for single write and
// round-robin, hand sequences for starvation, r0, streaming and mid-run reset,
// and a per-requester scoreboard checking every write that reaches the port.
module tb_regfile_wb_arbiter;
  import gemips_pkg::*;

  localparam int W = 37;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0, req_valid_2 = 1'b0;
  logic        req_ready_0, req_ready_1, req_ready_2;
  logic [4:0]  req_addr_0 = '0, req_addr_1 = '0, req_addr_2 = '0;
  logic [31:0] req_data_0 = '0, req_data_1 = '0, req_data_2 = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  grant_id;
  logic [31:0] pending_mask;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  // clock / reset
  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1), .req_valid_2(req_valid_2),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1), .req_ready_2(req_ready_2),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1), .req_addr_2(req_addr_2),
    .req_data_0(req_data_0), .req_data_1(req_data_1), .req_data_2(req_data_2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .grant_id(grant_id), .pending_mask(pending_mask)
  );

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        e_we;
    logic [1:0]  e_gid;
    logic [4:0]  e_waddr;
    logic [2:0]  e_rdy;   // {ready_2, ready_1, ready_0}
    logic [31:0] e_mask;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                              input logic [31:0] d0, d1, d2, input logic e_we,
                              input logic [1:0] e_gid, input logic [4:0] e_waddr,
                              input logic [2:0] e_rdy, input logic [31:0] e_mask);
    vec_t r;
    r.v = v; r.a0 = a0; r.a1 = a1; r.a2 = a2;
    r.d0 = d0; r.d1 = d1; r.d2 = d2;
    r.e_we = e_we; r.e_gid = e_gid; r.e_waddr = e_waddr;
    r.e_rdy = e_rdy; r.e_mask = e_mask;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    case (i)
      0: begin req_valid_0 = v; req_addr_0 = a; req_data_0 = d; end
      1: begin req_valid_1 = v; req_addr_1 = a; req_data_1 = d; end
      default: begin req_valid_2 = v; req_addr_2 = a; req_data_2 = d; end
    endcase
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 5'd0, 32'd0);
    drive(1, 1'b0, 5'd0, 32'd0);
    drive(2, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: check port writes, then record accepted requests
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    logic have;
    if (!rst) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
    end else begin
      if (rf_we) begin
        got = {rf_waddr, rf_wdata};
        exp = '0;
        have = 1'b0;
        if (grant_id == 2'd0 && exp_q0.size() > 0) begin exp = exp_q0.pop_front(); have = 1'b1; end
        if (grant_id == 2'd1 && exp_q1.size() > 0) begin exp = exp_q1.pop_front(); have = 1'b1; end
        if (grant_id == 2'd2 && exp_q2.size() > 0) begin exp = exp_q2.pop_front(); have = 1'b1; end
        n_cmp++;
        if (!have || got !== exp) begin
          n_err++;
          $display("FAIL sb_write: gid %0d got %0h expected %0h (queued=%0b) at %0t",
                   grant_id, got, exp, have, $time);
        end
      end
      if (req_valid_0 && req_ready_0 && req_addr_0 != 5'd0) exp_q0.push_back({req_addr_0, req_data_0});
      if (req_valid_1 && req_ready_1 && req_addr_1 != 5'd0) exp_q1.push_back({req_addr_1, req_data_1});
      if (req_valid_2 && req_ready_2 && req_addr_2 != 5'd0) exp_q2.push_back({req_addr_2, req_data_2});
    end
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    logic [31:0] sdat[10];
    int idx;

    // single write to r5, then requesters 1/2 streaming r8/r9
    vecs[0]  = mk(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 2'd3, 5'd0, 3'b111, 32'h0);
    vecs[1]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,       1'b0, 2'd3, 5'd0, 3'b111, 32'h20);
    vecs[2]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,       1'b1, 2'd0, 5'd5, 3'b111, 32'h20);
    vecs[3]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,       1'b0, 2'd3, 5'd0, 3'b111, 32'h0);
    vecs[4]  = mk(3'b110, 5'd0, 5'd8, 5'd9, 32'h0, 32'h10000004, 32'h20000004, 1'b0, 2'd3, 5'd0, 3'b111, 32'h0);
    vecs[5]  = mk(3'b110, 5'd0, 5'd8, 5'd9, 32'h0, 32'h10000005, 32'h20000005, 1'b0, 2'd3, 5'd0, 3'b011, 32'h300);
    vecs[6]  = mk(3'b110, 5'd0, 5'd8, 5'd9, 32'h0, 32'h10000006, 32'h20000006, 1'b1, 2'd1, 5'd8, 3'b101, 32'h300);
    vecs[7]  = mk(3'b110, 5'd0, 5'd8, 5'd9, 32'h0, 32'h10000007, 32'h20000007, 1'b1, 2'd2, 5'd9, 3'b011, 32'h300);
    vecs[8]  = mk(3'b110, 5'd0, 5'd8, 5'd9, 32'h0, 32'h10000008, 32'h20000008, 1'b1, 2'd1, 5'd8, 3'b101, 32'h300);
    vecs[9]  = mk(3'b110, 5'd0, 5'd8, 5'd9, 32'h0, 32'h10000009, 32'h20000009, 1'b1, 2'd2, 5'd9, 3'b011, 32'h300);
    vecs[10] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,       1'b1, 2'd1, 5'd8, 3'b101, 32'h300);
    vecs[11] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,       1'b1, 2'd2, 5'd9, 3'b111, 32'h300);
    vecs[12] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,       1'b1, 2'd1, 5'd8, 3'b111, 32'h100);
    vecs[13] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,       1'b0, 2'd3, 5'd0, 3'b111, 32'h0);

    // reset state
    idle_all();
    @(negedge clk);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd3);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_ready", 64'({req_ready_2, req_ready_1, req_ready_0}), 64'h7);
    tick();
    rst = 1'b1;

    // vector table
    for (int i = 0; i < 14; i++) begin
      drive(0, vecs[i].v[0], vecs[i].a0, vecs[i].d0);
      drive(1, vecs[i].v[1], vecs[i].a1, vecs[i].d1);
      drive(2, vecs[i].v[2], vecs[i].a2, vecs[i].d2);
      @(negedge clk);
      chk("vec_we", 64'(rf_we), 64'(vecs[i].e_we));
      chk("vec_gid", 64'(grant_id), 64'(vecs[i].e_gid));
      chk("vec_ready", 64'({req_ready_2, req_ready_1, req_ready_0}), 64'(vecs[i].e_rdy));
      chk("vec_mask", 64'(pending_mask), 64'(vecs[i].e_mask));
      if (vecs[i].e_we) chk("vec_waddr", 64'(rf_waddr), 64'(vecs[i].e_waddr));
      tick();
    end
    idle_all();

    // starvation guard: requester 0 every cycle, requester 1 offers r10 once
    for (int i = 0; i < 10; i++) sdat[i] = $urandom;
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      if (idx < 10) drive(0, 1'b1, 5'(11 + idx), sdat[idx]);
      else drive(0, 1'b0, 5'd0, 32'd0);
      if (c == 0) drive(1, 1'b1, 5'd10, 32'h1234);
      else drive(1, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("starve_ready0", 64'(req_ready_0), (c == 5) ? 64'd0 : 64'd1);
      if (c >= 2 && c <= 12) chk("starve_gid", 64'(grant_id), (c == 6) ? 64'd1 : 64'd0);
      if (c == 6) chk("starve_waddr", 64'(rf_waddr), 64'd10);
      if (req_valid_0 && req_ready_0) idx++;
      tick();
    end
    idle_all();
    chk("starve_all_sent", 64'(idx), 64'd10);

    // write to r0 is accepted and vanishes
    drive(2, 1'b1, 5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("zero_ready2", 64'(req_ready_2), 64'd1);
    tick();
    idle_all();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("zero_we", 64'(rf_we), 64'd0);
      chk("zero_mask", 64'(pending_mask), 64'd0);
      tick();
    end

    // back-to-back stream r1..r8 from requester 0
    for (int c = 0; c < 10; c++) begin
      if (c < 8) drive(0, 1'b1, 5'(c + 1), $urandom);
      else drive(0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      if (c < 8) chk("stream_ready0", 64'(req_ready_0), 64'd1);
      if (c >= 2) begin
        chk("stream_we", 64'(rf_we), 64'd1);
        chk("stream_waddr", 64'(rf_waddr), 64'(c - 1));
      end
      tick();
    end
    @(negedge clk);
    chk("stream_end_we", 64'(rf_we), 64'd0);
    tick();

    // reset with all slots full; pre-reset writes must never reach the port
    drive(0, 1'b1, 5'd20, 32'hA0A0A0A0);
    drive(1, 1'b1, 5'd21, 32'hA1A1A1A1);
    drive(2, 1'b1, 5'd22, 32'hA2A2A2A2);
    @(negedge clk);
    tick();
    idle_all();
    chk("full_mask", 64'(pending_mask), 64'h700000);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_mask", 64'(pending_mask), 64'd0);
    chk("mid_rst_ready", 64'({req_ready_2, req_ready_1, req_ready_0}), 64'h7);
    chk("mid_rst_gid", 64'(grant_id), 64'd3);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_we", 64'(rf_we), 64'd0);
      chk("post_rst_mask", 64'(pending_mask), 64'd0);
      tick();
    end

    // every accepted write must have reached the port exactly once
    chk("q0_empty", 64'(exp_q0.size()), 64'd0);
    chk("q1_empty", 64'(exp_q1.size()), 64'd0);
    chk("q2_empty", 64'(exp_q2.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
